// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE/LAP state machine, ms:s counter with sticky
// overflow, lap capture and a display mux that shows the frozen lap value while in LAP.
module stopwatch_ctrl #(
  parameter int MS_MAX  = 999,
  parameter int SEC_MAX = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1ms,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [5:0] seconds,
  output logic [9:0] milliseconds,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam logic [9:0] MS_TOP  = 10'(MS_MAX);
  localparam logic [5:0] SEC_TOP = 6'(SEC_MAX);

  state_t     state_r;
  state_t     state_nxt;
  logic [9:0] ms_cnt_r;
  logic [9:0] ms_cnt_nxt;
  logic [5:0] sec_cnt_r;
  logic [5:0] sec_cnt_nxt;
  logic [9:0] lap_ms_r;
  logic [9:0] lap_ms_nxt;
  logic [5:0] lap_sec_r;
  logic [5:0] lap_sec_nxt;
  logic       overflow_r;
  logic       overflow_nxt;
  logic       running_r;
  logic       lap_active_r;
  logic       counting_s;
  logic       do_clear_s;
  logic       do_capture_s;

  // Next-state decode; the if/else chains encode clear > start_stop > lap within each state.
  always_comb begin
    state_nxt    = state_r;
    do_clear_s   = 1'b0;
    do_capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (btn_start_stop) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (btn_start_stop) begin
          state_nxt = PAUSE;
        end else if (btn_lap) begin
          state_nxt    = LAP;
          do_capture_s = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      LAP: begin
        if (btn_start_stop) begin
          state_nxt = PAUSE;
        end else if (btn_lap) begin
          state_nxt = RUN;
        end else begin
          state_nxt = LAP;
        end
      end
      PAUSE: begin
        if (btn_clear) begin
          state_nxt  = IDLE;
          do_clear_s = 1'b1;
        end else if (btn_start_stop) begin
          state_nxt = RUN;
        end else begin
          state_nxt = PAUSE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Ticks count only on the pre-edge state, so a start in IDLE misses a coincident tick.
  always_comb begin
    counting_s = (state_r == RUN) || (state_r == LAP);
  end

  // Counter update; >= comparisons keep the counters bounded even from an unexpected value.
  always_comb begin
    ms_cnt_nxt   = ms_cnt_r;
    sec_cnt_nxt  = sec_cnt_r;
    overflow_nxt = overflow_r;
    if (do_clear_s) begin
      ms_cnt_nxt   = 10'd0;
      sec_cnt_nxt  = 6'd0;
      overflow_nxt = 1'b0;
    end else if (counting_s && tick_1ms) begin
      if (ms_cnt_r >= MS_TOP) begin
        ms_cnt_nxt = 10'd0;
        if (sec_cnt_r >= SEC_TOP) begin
          sec_cnt_nxt  = 6'd0;
          overflow_nxt = 1'b1;
        end else begin
          sec_cnt_nxt = sec_cnt_r + 6'd1;
        end
      end else begin
        ms_cnt_nxt = ms_cnt_r + 10'd1;
      end
    end else begin
      ms_cnt_nxt   = ms_cnt_r;
      sec_cnt_nxt  = sec_cnt_r;
      overflow_nxt = overflow_r;
    end
  end

  // Lap registers take the pre-edge live count on the RUN->LAP edge.
  always_comb begin
    lap_ms_nxt  = lap_ms_r;
    lap_sec_nxt = lap_sec_r;
    if (do_clear_s) begin
      lap_ms_nxt  = 10'd0;
      lap_sec_nxt = 6'd0;
    end else if (do_capture_s) begin
      lap_ms_nxt  = ms_cnt_r;
      lap_sec_nxt = sec_cnt_r;
    end else begin
      lap_ms_nxt  = lap_ms_r;
      lap_sec_nxt = lap_sec_r;
    end
  end

  // State, counters and lap registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      ms_cnt_r   <= 10'd0;
      sec_cnt_r  <= 6'd0;
      lap_ms_r   <= 10'd0;
      lap_sec_r  <= 6'd0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      ms_cnt_r   <= ms_cnt_nxt;
      sec_cnt_r  <= sec_cnt_nxt;
      lap_ms_r   <= lap_ms_nxt;
      lap_sec_r  <= lap_sec_nxt;
      overflow_r <= overflow_nxt;
    end
  end

  // Status flags get their own flops so they are glitch-free and always track state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_r    <= 1'b0;
      lap_active_r <= 1'b0;
    end else begin
      running_r    <= (state_nxt == RUN) || (state_nxt == LAP);
      lap_active_r <= (state_nxt == LAP);
    end
  end

  // Display mux: combinational on registers, no added latency.
  always_comb begin
    if (state_r == LAP) begin
      seconds      = lap_sec_r;
      milliseconds = lap_ms_r;
    end else begin
      seconds      = sec_cnt_r;
      milliseconds = ms_cnt_r;
    end
  end

  assign running    = running_r;
  assign lap_active = lap_active_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (default limits and tiny limits) share stimulus and are
// compared every cycle against a total-elapsed-milliseconds model; directed literals pin the model.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick_1ms = 1'b0;
  logic btn_start_stop = 1'b0;
  logic btn_lap = 1'b0;
  logic btn_clear = 1'b0;

  logic [5:0] a_sec;
  logic [9:0] a_ms;
  logic       a_run, a_lap, a_ovf;
  logic [5:0] b_sec;
  logic [9:0] b_ms;
  logic       b_run, b_lap, b_ovf;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: mode 0 stopped-at-zero, 1 running, 2 paused, 3 running with frozen lap
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
  int lim_ms[2]  = '{1000, 10};
  int lim_sec[2] = '{60, 4};
  int m_mode[2];
  int m_total[2];
  int m_lap[2];
  int m_ovf[2];

  stopwatch_ctrl u_a (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .btn_start_stop(btn_start_stop),
    .btn_lap(btn_lap), .btn_clear(btn_clear), .seconds(a_sec), .milliseconds(a_ms),
    .running(a_run), .lap_active(a_lap), .overflow(a_ovf)
  );

  stopwatch_ctrl #(.MS_MAX(9), .SEC_MAX(3)) u_b (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .btn_start_stop(btn_start_stop),
    .btn_lap(btn_lap), .btn_clear(btn_clear), .seconds(b_sec), .milliseconds(b_ms),
    .running(b_run), .lap_active(b_lap), .overflow(b_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_total[i] = 0; m_lap[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step(input bit t, input bit ss, input bit lp, input bit cl);
    for (int i = 0; i < 2; i++) begin
      int old;
      old = m_total[i];
      if ((m_mode[i] == M_RUN || m_mode[i] == M_LAP) && t) begin
        m_total[i] = (m_total[i] + 1) % (lim_ms[i] * lim_sec[i]);
        if (m_total[i] == 0) m_ovf[i] = 1;
      end
      if (m_mode[i] == M_PAUSE && cl) begin
        m_mode[i] = M_IDLE; m_total[i] = 0; m_lap[i] = 0; m_ovf[i] = 0;
      end else if (ss) begin
        m_mode[i] = (m_mode[i] == M_IDLE || m_mode[i] == M_PAUSE) ? M_RUN : M_PAUSE;
      end else if (lp && m_mode[i] == M_RUN) begin
        m_mode[i] = M_LAP; m_lap[i] = old;
      end else if (lp && m_mode[i] == M_LAP) begin
        m_mode[i] = M_RUN;
      end
    end
  endtask

  task automatic cmp_inst(input int i, input int sec, input int ms, input int run, input int lap,
                          input int ovf);
    int disp;
    disp = (m_mode[i] == M_LAP) ? m_lap[i] : m_total[i];
    chk($sformatf("inst%0d seconds", i), sec, disp / lim_ms[i]);
    chk($sformatf("inst%0d milliseconds", i), ms, disp % lim_ms[i]);
    chk($sformatf("inst%0d running", i), run, int'(m_mode[i] == M_RUN || m_mode[i] == M_LAP));
    chk($sformatf("inst%0d lap_active", i), lap, int'(m_mode[i] == M_LAP));
    chk($sformatf("inst%0d overflow", i), ovf, m_ovf[i]);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst(0, int'(a_sec), int'(a_ms), int'(a_run), int'(a_lap), int'(a_ovf));
      cmp_inst(1, int'(b_sec), int'(b_ms), int'(b_run), int'(b_lap), int'(b_ovf));
    end
  end

  task automatic cycle(input bit t, input bit ss, input bit lp, input bit cl);
    tick_1ms = t; btn_start_stop = ss; btn_lap = lp; btn_clear = cl;
    @(posedge clk);
    model_step(t, ss, lp, cl);
    #1;
    tick_1ms = 1'b0; btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic expect_a(input string nm, input int sec, input int ms, input int run,
                          input int lap, input int ovf);
    chk({nm, " seconds"}, int'(a_sec), sec);
    chk({nm, " milliseconds"}, int'(a_ms), ms);
    chk({nm, " running"}, int'(a_run), run);
    chk({nm, " lap_active"}, int'(a_lap), lap);
    chk({nm, " overflow"}, int'(a_ovf), ovf);
  endtask

  task automatic expect_b(input string nm, input int sec, input int ms, input int run,
                          input int lap, input int ovf);
    chk({nm, " seconds"}, int'(b_sec), sec);
    chk({nm, " milliseconds"}, int'(b_ms), ms);
    chk({nm, " running"}, int'(b_run), run);
    chk({nm, " lap_active"}, int'(b_lap), lap);
    chk({nm, " overflow"}, int'(b_ovf), ovf);
  endtask

  initial begin
    model_reset();
    #2;
    reset = 1'b1;
    btn_start_stop = 1'b1;
    tick_1ms = 1'b1;
    @(posedge clk);
    #1;
    expect_a("under_reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0; btn_start_stop = 1'b0; tick_1ms = 1'b0;
    cmp_en = 1'b1;
    expect_a("after_reset", 0, 0, 0, 0, 0);

    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    expect_a("idle_ignore_lap_clear", 0, 0, 0, 0, 0);

    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    expect_a("start_with_tick", 0, 0, 1, 0, 0);

    ticks(1500);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    expect_a("run1500_stop", 1, 500, 0, 0, 0);

    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    expect_a("pause_ignore_lap", 1, 500, 0, 0, 0);

    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(749);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    expect_a("run_ignore_clear", 2, 250, 1, 0, 0);

    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    expect_a("lap_enter", 2, 250, 1, 1, 0);
    ticks(300);
    expect_a("lap_frozen", 2, 250, 1, 1, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    expect_a("lap_release", 2, 550, 1, 0, 0);

    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    expect_a("stop_with_tick", 2, 551, 0, 0, 0);

    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    expect_a("pause_clear_and_start", 0, 0, 0, 0, 0);

    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10123);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(877);
    expect_a("lap_10_123", 10, 123, 1, 1, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    expect_a("async_reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(39);
    expect_b("b_at_top", 3, 9, 1, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    expect_b("b_wrap", 0, 0, 1, 0, 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    expect_b("b_stop_keeps_ovf", 0, 0, 0, 0, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    expect_b("b_clear_ovf", 0, 0, 0, 0, 0);

    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        bit t, ss, lp, cl;
        t  = 1'($urandom_range(0, 1));
        ss = ($urandom_range(0, 19) == 0);
        cl = ($urandom_range(0, 29) == 0);
        lp = !t && ($urandom_range(0, 7) == 0);
        cycle(t, ss, lp, cl);
      end
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
